// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - SECDED code geometry helpers and error-type encoding
package ecc_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_SBE  = 2'd1,
        ERR_DBE  = 2'd2
    } err_type_e;

    localparam int MAX_PARITY_WIDTH = 8;

    function automatic int parity_width(input int data_width);
        int r;
        r = 1;
        while ((1 << r) < data_width + r + 1) r++;
        return r + 1;
    endfunction

    // Column = i-th non-power-of-two Hamming position, MSB added for odd weight.
    function automatic logic [MAX_PARITY_WIDTH-1:0] code_col(input int data_width, input int idx);
        int r;
        int pos;
        int k;
        logic [MAX_PARITY_WIDTH-1:0] col;
        r   = parity_width(data_width) - 1;
        pos = 2;
        k   = -1;
        while (k < idx) begin
            pos++;
            if ((pos & (pos - 1)) != 0) k++;
        end
        col = MAX_PARITY_WIDTH'(pos);
        if (($countones(col) % 2) == 0) col[r] = 1'b1;
        return col;
    endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// rtl/ecc_secded_pipe_if.sv - decode-side read word and corrected word handshake bundle
interface ecc_secded_pipe_if import ecc_pkg::*; #(
    parameter int DATA_WIDTH = 14
) ();
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH);

    logic                    dec_valid_in;
    logic                    dec_ready_out;
    logic [DATA_WIDTH-1:0]   dec_data_in;
    logic [PARITY_WIDTH-1:0] dec_parity_in;
    logic                    bypass;
    logic                    dec_valid_out;
    logic                    dec_ready_in;
    logic [DATA_WIDTH-1:0]   dec_data_out;
    logic                    dec_sbit_err;
    logic                    dec_dbit_err;

    modport master (
        output dec_valid_in, dec_data_in, dec_parity_in, bypass, dec_ready_in,
        input  dec_ready_out, dec_valid_out, dec_data_out, dec_sbit_err, dec_dbit_err
    );

    modport slave (
        input  dec_valid_in, dec_data_in, dec_parity_in, bypass, dec_ready_in,
        output dec_ready_out, dec_valid_out, dec_data_out, dec_sbit_err, dec_dbit_err
    );
endinterface

// File: rtl/ecc_secded_core.sv
// rtl/ecc_secded_core.sv - combinational SECDED check-bit generation, syndrome and correction
module ecc_secded_core import ecc_pkg::*; #(
    parameter  int DATA_WIDTH   = 14,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    output logic [PARITY_WIDTH-1:0] parity_calc,
    output logic [PARITY_WIDTH-1:0] syndrome,
    output logic [DATA_WIDTH-1:0]   data_corr,
    output err_type_e               err_type
);
    logic [PARITY_WIDTH-1:0] cols [DATA_WIDTH];
    logic                    col_hit;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
        localparam logic [MAX_PARITY_WIDTH-1:0] COL = code_col(DATA_WIDTH, i);
        assign cols[i] = COL[PARITY_WIDTH-1:0];
    end

    always_comb begin
        parity_calc = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            parity_calc = parity_calc ^ (cols[i] & {PARITY_WIDTH{data_in[i]}});
        end
        syndrome  = parity_calc ^ parity_in;
        data_corr = data_in;
        col_hit   = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (syndrome == cols[i]) begin
                data_corr[i] = ~data_in[i];
                col_hit      = 1'b1;
            end
        end
        // One-hot syndromes can never match a data column (all have weight >= 3).
        if (syndrome == '0)                      err_type = ERR_NONE;
        else if (col_hit || $onehot(syndrome))   err_type = ERR_SBE;
        else                                     err_type = ERR_DBE;
    end
endmodule

// File: rtl/ecc_secded_pipe.sv
// rtl/ecc_secded_pipe.sv - pipelined SECDED codec with error counters; ECC_ERR_INJECT_EN adds inj_mask
module ecc_secded_pipe import ecc_pkg::*; #(
    parameter  int DATA_WIDTH   = 14,
    parameter  int CNT_WIDTH    = 8,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH-1:0]              enc_data_in,
    output logic [PARITY_WIDTH-1:0]            enc_parity_out,
    ecc_secded_pipe_if.slave                   dec,
    input  logic                               cnt_clr,
`ifdef ECC_ERR_INJECT_EN
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] inj_mask,
`endif
    output logic [CNT_WIDTH-1:0]               sbe_cnt,
    output logic [CNT_WIDTH-1:0]               dbe_cnt,
    output logic [PARITY_WIDTH-1:0]            err_syn,
    output logic                               err_syn_vld
);
    logic [PARITY_WIDTH-1:0]            enc_unused_syn;
    logic [DATA_WIDTH-1:0]              enc_unused_data;
    err_type_e                          enc_unused_err;
    logic [PARITY_WIDTH-1:0]            dec_unused_parity;
    logic [DATA_WIDTH+PARITY_WIDTH-1:0] dec_word;
    logic [PARITY_WIDTH-1:0]            dec_syn;
    logic [DATA_WIDTH-1:0]              dec_data_corr;
    err_type_e                          dec_err;

    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .data_in     (enc_data_in),
        .parity_in   ('0),
        .parity_calc (enc_parity_out),
        .syndrome    (enc_unused_syn),
        .data_corr   (enc_unused_data),
        .err_type    (enc_unused_err)
    );

`ifdef ECC_ERR_INJECT_EN
    assign dec_word = {dec.dec_parity_in, dec.dec_data_in} ^ inj_mask;
`else
    assign dec_word = {dec.dec_parity_in, dec.dec_data_in};
`endif

    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .data_in     (dec_word[DATA_WIDTH-1:0]),
        .parity_in   (dec_word[DATA_WIDTH+PARITY_WIDTH-1:DATA_WIDTH]),
        .parity_calc (dec_unused_parity),
        .syndrome    (dec_syn),
        .data_corr   (dec_data_corr),
        .err_type    (dec_err)
    );

    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    sbit_q, sbit_d, dbit_q, dbit_d;
    logic [CNT_WIDTH-1:0]    sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
    logic [PARITY_WIDTH-1:0] err_syn_q, err_syn_d;
    logic                    err_syn_vld_q, err_syn_vld_d;
    logic                    accept, sbe_ev, dbe_ev;

    assign dec.dec_ready_out = !valid_q || dec.dec_ready_in;
    assign accept            = dec.dec_valid_in && dec.dec_ready_out;
    assign sbe_ev            = accept && !dec.bypass && (dec_err == ERR_SBE);
    assign dbe_ev            = accept && !dec.bypass && (dec_err == ERR_DBE);

    always_comb begin
        valid_d       = valid_q;
        data_d        = data_q;
        sbit_d        = sbit_q;
        dbit_d        = dbit_q;
        sbe_cnt_d     = sbe_cnt_q;
        dbe_cnt_d     = dbe_cnt_q;
        err_syn_d     = err_syn_q;
        err_syn_vld_d = err_syn_vld_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = dec.bypass ? dec.dec_data_in : dec_data_corr;
            sbit_d  = sbe_ev;
            dbit_d  = dbe_ev;
        end else if (valid_q && dec.dec_ready_in) begin
            valid_d = 1'b0;
        end
        // A clear coinciding with an error restarts the statistics from that error.
        if (cnt_clr) begin
            sbe_cnt_d     = sbe_ev ? CNT_WIDTH'(1) : '0;
            dbe_cnt_d     = dbe_ev ? CNT_WIDTH'(1) : '0;
            err_syn_d     = (sbe_ev || dbe_ev) ? dec_syn : '0;
            err_syn_vld_d = sbe_ev || dbe_ev;
        end else begin
            if (sbe_ev && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_WIDTH'(1);
            if (dbe_ev && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_WIDTH'(1);
            if ((sbe_ev || dbe_ev) && !err_syn_vld_q) begin
                err_syn_d     = dec_syn;
                err_syn_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            data_q        <= '0;
            sbit_q        <= 1'b0;
            dbit_q        <= 1'b0;
            sbe_cnt_q     <= '0;
            dbe_cnt_q     <= '0;
            err_syn_q     <= '0;
            err_syn_vld_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            data_q        <= data_d;
            sbit_q        <= sbit_d;
            dbit_q        <= dbit_d;
            sbe_cnt_q     <= sbe_cnt_d;
            dbe_cnt_q     <= dbe_cnt_d;
            err_syn_q     <= err_syn_d;
            err_syn_vld_q <= err_syn_vld_d;
        end
    end

    assign dec.dec_valid_out = valid_q;
    assign dec.dec_data_out  = data_q;
    assign dec.dec_sbit_err  = sbit_q;
    assign dec.dec_dbit_err  = dbit_q;
    assign sbe_cnt           = sbe_cnt_q;
    assign dbe_cnt           = dbe_cnt_q;
    assign err_syn           = err_syn_q;
    assign err_syn_vld       = err_syn_vld_q;
endmodule
